// File: rtl/battle_pkg.sv
// Shared definitions for the battle sequencer and every phase block that
// decodes its broadcast state: state encodings, bus widths, menu codes and
// a saturating counter helper.
package battle_pkg;

    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned VCOUNT_W = 10;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned EHP_W    = 11;
    localparam int unsigned PHP_W    = 8;
    localparam int unsigned TURN_W   = 8;
    localparam int unsigned TIMER_W  = 12;
    localparam int unsigned STATE_W  = 4;

    localparam logic [SEL_W-1:0] MENU_FIGHT = SEL_W'(0);

    // Phase blocks decode these exact codes; do not renumber.
    typedef enum logic [STATE_W-1:0] {
        ST_MENU   = 4'b0000,
        ST_PLAYER = 4'b0001,
        ST_ENEMY  = 4'b0010,
        ST_GAP    = 4'b0011,
        ST_WIN    = 4'b0100,
        ST_LOSE   = 4'b1000,
        ST_TITLE  = 4'b1010
    } state_e;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [TURN_W-1:0] sat_inc(input logic [TURN_W-1:0] v);
        return (v == {TURN_W{1'b1}}) ? v : TURN_W'(v + TURN_W'(1));
    endfunction

endpackage

// File: rtl/battle_sequencer_if.sv
// Bundle between the battle sequencer and the rest of the game.
//   slave  : the sequencer (raster, button, menu, phase-done and HP in;
//            state, turn count and timeout flag out)
//   master : the game side driving those inputs and observing the outputs
interface battle_sequencer_if;
    import battle_pkg::*;

    logic [HCOUNT_W-1:0] hcount_in;
    logic [VCOUNT_W-1:0] vcount_in;
    logic                start_in;
    logic [SEL_W-1:0]    menu_sel_in;
    logic                player_finished_in;
    logic                enemy_finished_in;
    logic [EHP_W-1:0]    enemy_hp_in;
    logic [PHP_W-1:0]    player_hp_in;
    logic [STATE_W-1:0]  state_out;
    logic [TURN_W-1:0]   turn_count_out;
    logic                timeout_out;

    modport slave (
        input  hcount_in, vcount_in, start_in, menu_sel_in,
               player_finished_in, enemy_finished_in, enemy_hp_in, player_hp_in,
        output state_out, turn_count_out, timeout_out
    );

    modport master (
        output hcount_in, vcount_in, start_in, menu_sel_in,
               player_finished_in, enemy_finished_in, enemy_hp_in, player_hp_in,
        input  state_out, turn_count_out, timeout_out
    );

endinterface

// File: rtl/frame_timer.sv
// Frame-tick detector plus phase frame counter.
//   clk, rst     : clock, async active-low reset
//   hcount/vcount: raster position; a tick is the (0,0) pixel
//   clear        : zero the counter (owner asserts it on every state change)
//   limit        : frame count that ends the current phase
//   at_limit_c   : combinational, high on the tick that brings count to limit
module frame_timer
    import battle_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    input  logic                clear,
    input  logic [TIMER_W-1:0]  limit,
    output logic                at_limit_c
);

    logic               tick_c;
    logic [TIMER_W-1:0] count_q;

    assign tick_c = (hcount == '0) && (vcount == '0);

    // Clear has priority so a tick on the entry edge is not counted twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (tick_c) begin
            count_q <= TIMER_W'(count_q + TIMER_W'(1));
        end
    end

    assign at_limit_c = tick_c && (TIMER_W'(count_q + TIMER_W'(1)) == limit);

endmodule

// File: rtl/battle_sequencer.sv
// Top-level battle state machine: title, menu, player attack, gap, enemy
// attack, win and lose, with per-phase frame timeout.
//   clk : pixel/system clock
//   rst : async active-low reset; release is expected to be synchronised
//         to clk by the reset source
//   bus : battle_sequencer_if.slave (inputs from the game, registered
//         state_out / turn_count_out / timeout_out)
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int unsigned TIMEOUT_FRAMES = 1800,
    parameter int unsigned GAP_FRAMES     = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    battle_sequencer_if.slave    bus
);

    state_e              state_q, state_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic                timeout_q, timeout_d;
    logic                entry_q;
    logic                phase_change_c;
    logic [TIMER_W-1:0]  limit_c;
    logic                at_limit_c;
    logic                player_done_c;
    logic                enemy_done_c;

    // The gap uses its own length; attack phases use the timeout.
    assign limit_c = (state_q == ST_GAP) ? TIMER_W'(GAP_FRAMES)
                                         : TIMER_W'(TIMEOUT_FRAMES);

    assign phase_change_c = (state_d != state_q);

    frame_timer u_frame_timer (
        .clk        (clk),
        .rst        (rst),
        .hcount     (bus.hcount_in),
        .vcount     (bus.vcount_in),
        .clear      (phase_change_c),
        .limit      (limit_c),
        .at_limit_c (at_limit_c)
    );

    // A finished level left over from a previous phase is ignored on the
    // first cycle in the new phase.
    assign player_done_c = bus.player_finished_in && !entry_q;
    assign enemy_done_c  = bus.enemy_finished_in  && !entry_q;

    // Next-state and output update; finished has priority over timeout.
    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_TITLE: begin
                if (bus.start_in) begin
                    state_d   = ST_MENU;
                    turn_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_MENU: begin
                if (bus.start_in) begin
                    state_d = (bus.menu_sel_in == MENU_FIGHT) ? ST_PLAYER : ST_ENEMY;
                end
            end
            ST_PLAYER: begin
                if (player_done_c) begin
                    state_d = (bus.enemy_hp_in == '0) ? ST_WIN : ST_GAP;
                end else if (at_limit_c) begin
                    state_d   = ST_MENU;
                    timeout_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (at_limit_c) begin
                    state_d = ST_ENEMY;
                end
            end
            ST_ENEMY: begin
                if (enemy_done_c) begin
                    if (bus.player_hp_in == '0) begin
                        state_d = ST_LOSE;
                    end else begin
                        state_d = ST_MENU;
                        turn_d  = sat_inc(turn_q);
                    end
                end else if (at_limit_c) begin
                    state_d   = ST_MENU;
                    timeout_d = 1'b1;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (bus.start_in) begin
                    state_d = ST_TITLE;
                end
            end
            default: begin
                state_d = ST_TITLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_TITLE;
            turn_q    <= '0;
            timeout_q <= 1'b0;
            entry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            timeout_q <= timeout_d;
            entry_q   <= phase_change_c;
        end
    end

    assign bus.state_out      = state_q;
    assign bus.turn_count_out = turn_q;
    assign bus.timeout_out    = timeout_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer with default parameters
// (TIMEOUT_FRAMES=1800, GAP_FRAMES=30). Frame ticks are generated by
// driving the raster to (0,0) for one cycle out of every two.
module tb_battle_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    battle_sequencer_if bus ();

    battle_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] S_TITLE  = 4'b1010;
    localparam logic [3:0] S_MENU   = 4'b0000;
    localparam logic [3:0] S_PLAYER = 4'b0001;
    localparam logic [3:0] S_GAP    = 4'b0011;
    localparam logic [3:0] S_ENEMY  = 4'b0010;
    localparam logic [3:0] S_WIN    = 4'b0100;
    localparam logic [3:0] S_LOSE   = 4'b1000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame tick followed by one idle raster cycle.
    task automatic frame();
        bus.hcount_in = '0;
        bus.vcount_in = '0;
        cyc();
        bus.hcount_in = 11'd5;
        bus.vcount_in = 10'd5;
        cyc();
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        bus.menu_sel_in = sel;
        bus.start_in    = 1'b1;
        cyc();
        bus.start_in    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst                    = 1'b0;
        bus.hcount_in          = 11'd5;
        bus.vcount_in          = 10'd5;
        bus.start_in           = 1'b0;
        bus.menu_sel_in        = 2'b00;
        bus.player_finished_in = 1'b0;
        bus.enemy_finished_in  = 1'b0;
        bus.enemy_hp_in        = 11'd40;
        bus.player_hp_in       = 8'd20;

        cyc();
        cyc();
        chk("reset_state", 16'(bus.state_out), 16'(S_TITLE));
        chk("reset_turn", 16'(bus.turn_count_out), 16'd0);
        chk("reset_timeout", 16'(bus.timeout_out), 16'd0);

        rst = 1'b1;
        cyc();
        chk("title_idle", 16'(bus.state_out), 16'(S_TITLE));

        pulse_start(2'b00);
        chk("title_to_menu", 16'(bus.state_out), 16'(S_MENU));
        pulse_start(2'b00);
        chk("menu_fight", 16'(bus.state_out), 16'(S_PLAYER));

        pulse_start(2'b00);
        chk("start_ignored_player", 16'(bus.state_out), 16'(S_PLAYER));

        bus.player_finished_in = 1'b1;
        cyc();
        bus.player_finished_in = 1'b0;
        chk("player_to_gap", 16'(bus.state_out), 16'(S_GAP));

        for (int i = 0; i < 29; i++) frame();
        chk("gap_29_ticks", 16'(bus.state_out), 16'(S_GAP));
        bus.hcount_in = '0;
        bus.vcount_in = '0;
        cyc();
        bus.hcount_in = 11'd5;
        bus.vcount_in = 10'd5;
        chk("gap_30th_tick", 16'(bus.state_out), 16'(S_ENEMY));

        cyc();
        bus.enemy_finished_in = 1'b1;
        cyc();
        bus.enemy_finished_in = 1'b0;
        chk("enemy_to_menu", 16'(bus.state_out), 16'(S_MENU));
        chk("turn_one", 16'(bus.turn_count_out), 16'd1);

        // Finished already high on entry into PLAYER, enemy defeated.
        bus.enemy_hp_in        = 11'd0;
        bus.player_finished_in = 1'b1;
        pulse_start(2'b00);
        chk("stale_entry", 16'(bus.state_out), 16'(S_PLAYER));
        cyc();
        chk("stale_ignored", 16'(bus.state_out), 16'(S_PLAYER));
        cyc();
        chk("player_win", 16'(bus.state_out), 16'(S_WIN));
        bus.enemy_finished_in = 1'b1;
        cyc();
        bus.player_finished_in = 1'b0;
        bus.enemy_finished_in  = 1'b0;
        chk("win_terminal", 16'(bus.state_out), 16'(S_WIN));
        pulse_start(2'b00);
        chk("win_to_title", 16'(bus.state_out), 16'(S_TITLE));
        chk("title_keeps_turn", 16'(bus.turn_count_out), 16'd1);
        pulse_start(2'b00);
        chk("menu_again", 16'(bus.state_out), 16'(S_MENU));
        chk("turn_cleared", 16'(bus.turn_count_out), 16'd0);
        bus.enemy_hp_in = 11'd40;

        // Enemy finished on the same tick that would time out.
        pulse_start(2'b01);
        chk("menu_spare", 16'(bus.state_out), 16'(S_ENEMY));
        for (int i = 0; i < 1799; i++) frame();
        chk("enemy_1799", 16'(bus.state_out), 16'(S_ENEMY));
        bus.enemy_finished_in = 1'b1;
        bus.hcount_in = '0;
        bus.vcount_in = '0;
        cyc();
        bus.enemy_finished_in = 1'b0;
        bus.hcount_in = 11'd5;
        bus.vcount_in = 10'd5;
        chk("finish_wins_state", 16'(bus.state_out), 16'(S_MENU));
        chk("finish_wins_timeout", 16'(bus.timeout_out), 16'd0);
        chk("finish_wins_turn", 16'(bus.turn_count_out), 16'd1);

        // Pure timeout.
        pulse_start(2'b10);
        for (int i = 0; i < 1799; i++) frame();
        chk("timeout_pending", 16'(bus.timeout_out), 16'd0);
        bus.hcount_in = '0;
        bus.vcount_in = '0;
        cyc();
        bus.hcount_in = 11'd5;
        bus.vcount_in = 10'd5;
        chk("timeout_state", 16'(bus.state_out), 16'(S_MENU));
        chk("timeout_flag", 16'(bus.timeout_out), 16'd1);
        chk("timeout_turn", 16'(bus.turn_count_out), 16'd1);

        // Lose path, then title clears sticky flag.
        bus.player_hp_in = 8'd0;
        pulse_start(2'b11);
        cyc();
        bus.enemy_finished_in = 1'b1;
        cyc();
        bus.enemy_finished_in = 1'b0;
        bus.player_hp_in = 8'd20;
        chk("enemy_lose", 16'(bus.state_out), 16'(S_LOSE));
        pulse_start(2'b00);
        chk("lose_to_title", 16'(bus.state_out), 16'(S_TITLE));
        pulse_start(2'b00);
        chk("timeout_cleared", 16'(bus.timeout_out), 16'd0);
        chk("turn_cleared2", 16'(bus.turn_count_out), 16'd0);

        // Saturating turn counter.
        for (int i = 0; i < 255; i++) begin
            pulse_start(2'b01);
            cyc();
            bus.enemy_finished_in = 1'b1;
            cyc();
            bus.enemy_finished_in = 1'b0;
        end
        chk("turn_255", 16'(bus.turn_count_out), 16'd255);
        chk("turn_255_state", 16'(bus.state_out), 16'(S_MENU));
        pulse_start(2'b01);
        cyc();
        bus.enemy_finished_in = 1'b1;
        cyc();
        bus.enemy_finished_in = 1'b0;
        chk("turn_saturate", 16'(bus.turn_count_out), 16'd255);

        // Asynchronous reset mid-ENEMY, observed before the next edge.
        pulse_start(2'b01);
        cyc();
        chk("pre_reset_enemy", 16'(bus.state_out), 16'(S_ENEMY));
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_state", 16'(bus.state_out), 16'(S_TITLE));
        chk("async_reset_turn", 16'(bus.turn_count_out), 16'd0);
        bus.enemy_finished_in = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        bus.enemy_finished_in = 1'b0;
        chk("post_reset_needs_start", 16'(bus.state_out), 16'(S_TITLE));
        pulse_start(2'b00);
        chk("post_reset_start", 16'(bus.state_out), 16'(S_MENU));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
